// File: rtl/aux_slot_pkg.sv
// rtl/aux_slot_pkg.sv - bus phase constants and shared types for the Apple IIe aux-slot host
package aux_slot_pkg;

    typedef logic [3:0] phase_t;
    typedef logic [6:0] cycle_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        aux;
    } cmd_t;

    localparam phase_t P_VID_RAS   = 4'd2;
    localparam phase_t P_VID_CAS   = 4'd4;
    localparam phase_t P_CMD       = 4'd6;
    localparam phase_t P_PHI0      = 4'd7;
    localparam phase_t P_MD_DRIVE  = 4'd8;
    localparam phase_t P_CPU_RAS   = 4'd9;
    localparam phase_t P_CPU_CAS   = 4'd11;
    localparam phase_t P_LAST      = 4'd13;
    localparam phase_t P_LAST_LONG = 4'd15;
    localparam phase_t P_Q3_LEN    = 4'd4;

    localparam cycle_t CYCLE_LEN      = 7'd65;
    localparam cycle_t LONG_CYCLE_IDX = CYCLE_LEN - 7'd1;

    localparam logic [11:0] C07X_PAGE = 12'hC07;

    function automatic logic is_c07x(input logic [15:0] addr);
        return addr[15:4] == C07X_PAGE;
    endfunction

endpackage

// File: rtl/aux_slot_timing.sv
// rtl/aux_slot_timing.sv - phase/cycle counters and the C7M, Q3, PHI0, PHI1 bus clocks
module aux_slot_timing
    import aux_slot_pkg::*;
#(
    parameter bit LONG_CYCLE = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    output phase_t phase,
    output logic   last_tick,
    output logic   c7m,
    output logic   q3,
    output logic   phi0,
    output logic   phi1
);

    cycle_t cycle;

    // The final cycle of each 65-cycle frame is stretched by two ticks.
    assign last_tick = (phase == ((LONG_CYCLE && cycle == LONG_CYCLE_IDX) ? P_LAST_LONG : P_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            cycle <= '0;
        end else if (last_tick) begin
            phase <= '0;
            cycle <= (cycle == LONG_CYCLE_IDX) ? '0 : cycle + 7'd1;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    // Stretch ticks hold the P13 levels, except C7M which keeps toggling.
    assign c7m  = ~phase[0];
    assign phi1 = (phase < P_PHI0);
    assign phi0 = ~phi1;
    assign q3   = (phase < P_Q3_LEN) || (phase >= P_PHI0 && phase < P_PHI0 + P_Q3_LEN);

endmodule

// File: rtl/aux_slot_host.sv
// rtl/aux_slot_host.sv - aux-slot bus initiator: strobes, address mux, CPU and video data paths
module aux_slot_host
    import aux_slot_pkg::*;
#(
    parameter bit LONG_CYCLE = 1'b1
) (
    input  logic        C14M,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_aux,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    input  logic [15:0] vid_addr,
    input  logic        vid_aux,
    output logic        vid_valid,
    output logic [7:0]  vid_data,
    output logic        C7M,
    output logic        Q3,
    output logic        PHI0,
    output logic        PHI1,
    output logic        nPRAS,
    output logic        nPCAS,
    output logic        nWE,
    output logic        nWE80,
    output logic        nEN80,
    output logic        nC07X,
    output logic [7:0]  MA,
    inout  wire  [7:0]  MD,
    input  logic [7:0]  VD
);

    phase_t      phase;
    logic        last_tick;
    logic        act;
    cmd_t        cmd;
    logic [15:0] vid_lat;
    logic        cpu_strobe;

    aux_slot_timing #(.LONG_CYCLE(LONG_CYCLE)) timing (
        .clk       (C14M),
        .rst       (RST),
        .phase     (phase),
        .last_tick (last_tick),
        .c7m       (C7M),
        .q3        (Q3),
        .phi0      (PHI0),
        .phi1      (PHI1)
    );

    // act is only set from P7 to the last tick, so it doubles as the CPU-phase qualifier.
    assign cpu_strobe = act && (phase >= P_CPU_RAS);
    assign cmd_ready  = (phase == P_CMD);

    assign nPRAS = ~((phase >= P_VID_RAS && phase < P_PHI0) || phase >= P_CPU_RAS);
    assign nPCAS = ~((phase >= P_VID_CAS && phase < P_PHI0) || phase >= P_CPU_CAS);
    assign nWE   = ~(cpu_strobe && cmd.we);
    assign nEN80 = ~(cpu_strobe && cmd.aux);
    assign nWE80 = ~(cpu_strobe && cmd.we && cmd.aux);
    assign nC07X = ~(act && is_c07x(cmd.addr));

    assign MD = (act && cmd.we && phase >= P_MD_DRIVE) ? cmd.wdata : 8'hzz;

    always_comb begin
        MA = vid_lat[7:0];
        if (phase >= P_CPU_CAS)
            MA = cmd.addr[15:8];
        else if (phase >= P_PHI0)
            MA = cmd.addr[7:0];
        else if (phase >= P_VID_CAS)
            MA = vid_lat[15:8];
    end

    always_ff @(posedge C14M or posedge RST) begin
        if (RST) begin
            act       <= 1'b0;
            cmd       <= '0;
            vid_lat   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            rsp_valid <= last_tick && act && !cmd.we;
            vid_valid <= last_tick;
            if (last_tick) begin
                act     <= 1'b0;
                vid_lat <= vid_addr;
                if (act && !cmd.we)
                    rsp_data <= MD;
            end
            // Main-memory video is not modelled, so only aux fetches carry data.
            if (phase == P_CMD) begin
                vid_data <= vid_aux ? VD : 8'h00;
                if (cmd_valid) begin
                    act <= 1'b1;
                    cmd <= '{addr: cmd_addr, we: cmd_we, wdata: cmd_wdata, aux: cmd_aux};
                end
            end
        end
    end

endmodule

// File: tb/tb_aux_slot_host.sv
// tb/tb_aux_slot_host.sv - randomized bench for aux_slot_host, short and long cycle builds side by side
module tb_aux_slot_host;

    typedef struct {
        bit          v;
        bit          we;
        bit          aux;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  r;
    } cmd_t;

    // Bit i of each mask is the level at phase i.
    localparam logic [13:0] PHI1_HI = 14'b000_0000_111_1111;
    localparam logic [13:0] Q3_HI   = 14'b000_1111_000_1111;
    localparam logic [13:0] RAS_LO  = 14'b11111_00_11111_00;
    localparam logic [13:0] CAS_LO  = 14'b111_0000_111_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_aux = 1'b0, vid_aux = 1'b0;
    logic [15:0] cmd_addr = '0, vid_addr = '0;
    logic [7:0]  cmd_wdata = '0, vd = '0, rd_pick = '0;

    wire  [9:0]  sv0, sv1;
    wire  [7:0]  ma0, ma1, md0, md1, rd0, rd1, vdat0, vdat1;
    wire         cr0, cr1, rv0, rv1, vv0, vv1;

    logic        card_en  [2];
    logic [7:0]  card_val [2];

    int          mp [2], mcyc [2], tcnt [2], nlong [2];
    bit          act [2], mwe [2], maux [2], ersp [2], evv [2], prev_phi1 [2];
    logic [15:0] maddr [2], mvid [2];
    logic [7:0]  mwd [2], mrd [2], mrsp [2], evd [2];

    cmd_t        dq [$];
    int          n_assert = 0, n_fail = 0;

    assign md0 = card_en[0] ? card_val[0] : 8'hzz;
    assign md1 = card_en[1] ? card_val[1] : 8'hzz;

    always #5 clk = ~clk;

    aux_slot_host #(.LONG_CYCLE(1'b0)) dut0 (
        .C14M(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cr0), .cmd_addr(cmd_addr),
        .cmd_we(cmd_we), .cmd_wdata(cmd_wdata), .cmd_aux(cmd_aux), .rsp_valid(rv0), .rsp_data(rd0),
        .vid_addr(vid_addr), .vid_aux(vid_aux), .vid_valid(vv0), .vid_data(vdat0),
        .C7M(sv0[9]), .Q3(sv0[8]), .PHI0(sv0[7]), .PHI1(sv0[6]), .nPRAS(sv0[5]), .nPCAS(sv0[4]),
        .nWE(sv0[3]), .nWE80(sv0[2]), .nEN80(sv0[1]), .nC07X(sv0[0]), .MA(ma0), .MD(md0), .VD(vd)
    );

    aux_slot_host #(.LONG_CYCLE(1'b1)) dut1 (
        .C14M(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cr1), .cmd_addr(cmd_addr),
        .cmd_we(cmd_we), .cmd_wdata(cmd_wdata), .cmd_aux(cmd_aux), .rsp_valid(rv1), .rsp_data(rd1),
        .vid_addr(vid_addr), .vid_aux(vid_aux), .vid_valid(vv1), .vid_data(vdat1),
        .C7M(sv1[9]), .Q3(sv1[8]), .PHI0(sv1[7]), .PHI1(sv1[6]), .nPRAS(sv1[5]), .nPCAS(sv1[4]),
        .nWE(sv1[3]), .nWE80(sv1[2]), .nEN80(sv1[1]), .nC07X(sv1[0]), .MA(ma1), .MD(md1), .VD(vd)
    );

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mp[k] = 0; mcyc[k] = 0; act[k] = 0; mwe[k] = 0; maux[k] = 0;
            maddr[k] = '0; mwd[k] = '0; mrd[k] = '0; mvid[k] = '0;
            ersp[k] = 0; mrsp[k] = '0; evv[k] = 0; evd[k] = '0;
            tcnt[k] = 0; prev_phi1[k] = 1;
        end
    endtask

    // The card keeps the bus at 00 whenever the host should not be driving it.
    task automatic card_update();
        for (int k = 0; k < 2; k++) begin
            card_en[k]  = !(act[k] && mwe[k] && mp[k] >= 8);
            card_val[k] = (act[k] && !mwe[k] && mp[k] >= 9) ? mrd[k] : 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int last;
            last = (k == 1 && mcyc[k] == 64) ? 15 : 13;
            ersp[k] = 0;
            evv[k]  = (mp[k] == last);
            if (mp[k] == 6) begin
                evd[k] = vid_aux ? vd : 8'h00;
                if (cmd_valid) begin
                    act[k] = 1; mwe[k] = cmd_we; maux[k] = cmd_aux;
                    maddr[k] = cmd_addr; mwd[k] = cmd_wdata; mrd[k] = rd_pick;
                end
            end
            if (mp[k] == last) begin
                if (act[k] && !mwe[k]) begin
                    ersp[k] = 1;
                    mrsp[k] = mrd[k];
                end
                act[k] = 0; mvid[k] = vid_addr; mp[k] = 0;
                mcyc[k] = (mcyc[k] + 1) % 65;
            end else begin
                mp[k]++;
            end
        end
    endtask

    task automatic check_dut(input int k);
        int          p, pe, ended, elen;
        bit          cpu, chk_ma;
        logic [9:0]  esv, osv;
        logic [7:0]  ema, emd;
        p   = mp[k];
        pe  = (p > 13) ? 13 : p;
        cpu = act[k] && pe >= 9;
        osv = k ? sv1 : sv0;
        esv[9] = (p % 2) == 0;
        esv[8] = Q3_HI[pe];
        esv[7] = !PHI1_HI[pe];
        esv[6] = PHI1_HI[pe];
        esv[5] = !RAS_LO[pe];
        esv[4] = !CAS_LO[pe];
        esv[3] = !(cpu && mwe[k]);
        esv[2] = !(cpu && mwe[k] && maux[k]);
        esv[1] = !(cpu && maux[k]);
        esv[0] = !(act[k] && maddr[k][15:4] == 12'hC07);
        chk_ma = 1;
        ema = '0;
        if (p < 4)         ema = mvid[k][7:0];
        else if (p < 7)    ema = mvid[k][15:8];
        else if (!act[k])  chk_ma = 0;
        else if (p < 11)   ema = maddr[k][7:0];
        else               ema = maddr[k][15:8];
        emd = (act[k] && mwe[k] && p >= 8) ? mwd[k] : card_val[k];

        chk("strobes", k, osv, esv);
        if (chk_ma) chk("ma", k, k ? ma1 : ma0, ema);
        chk("md", k, k ? md1 : md0, emd);
        chk("cmd_ready", k, k ? cr1 : cr0, p == 6);
        chk("rsp_valid", k, k ? rv1 : rv0, ersp[k]);
        chk("rsp_data", k, k ? rd1 : rd0, mrsp[k]);
        chk("vid_valid", k, k ? vv1 : vv0, evv[k]);
        chk("vid_data", k, k ? vdat1 : vdat0, evd[k]);

        if (!rst) tcnt[k]++;
        if (osv[6] && !prev_phi1[k]) begin
            ended = (mcyc[k] + 64) % 65;
            elen  = (k == 1 && ended == 64) ? 16 : 14;
            chk("cycle_len", k, 16'(tcnt[k]), 16'(elen));
            if (tcnt[k] == 16) nlong[k]++;
            tcnt[k] = 0;
        end
        prev_phi1[k] = osv[6];
    endtask

    task automatic drive();
        cmd_t c;
        vd      = 8'($urandom);
        vid_aux = 1'($urandom);
        if (mp[0] == 8) vid_addr = 16'($urandom);
        c.v = 1'($urandom); c.we = 1'($urandom); c.aux = 1'($urandom);
        c.a = 16'($urandom); c.d = 8'($urandom); c.r = 8'($urandom);
        if (mp[0] == 6 || mp[1] == 6) begin
            if (dq.size() > 0) begin
                c = dq.pop_front();
            end else begin
                c.v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) c.a[15:4] = 12'hC07;
            end
            if (mp[1] == 6 && mcyc[1] == 64) begin
                c.v = 1; c.we = 0; c.aux = 1;
            end
        end
        cmd_valid = c.v; cmd_we = c.we; cmd_aux = c.aux;
        cmd_addr = c.a; cmd_wdata = c.d; rd_pick = c.r;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        card_update();
        #1;
        check_dut(0);
        check_dut(1);
        drive();
    endtask

    initial begin
        int guard;
        nlong[0] = 0; nlong[1] = 0;
        model_reset();
        card_update();
        #1;
        check_dut(0);
        check_dut(1);
        repeat (3) tick();
        rst = 1'b0;

        dq.push_back('{1'b1, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00});
        dq.push_back('{1'b1, 1'b0, 1'b1, 16'h2000, 8'hA5, 8'h5A});
        dq.push_back('{1'b1, 1'b1, 1'b0, 16'hC073, 8'h03, 8'h00});
        dq.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00});
        dq.push_back('{1'b1, 1'b0, 1'b0, 16'hC07F, 8'hFF, 8'h3C});
        repeat (40 * 14) tick();

        dq.push_back('{1'b1, 1'b1, 1'b1, 16'h4321, 8'h77, 8'h00});
        guard = 0;
        while (!(act[0] && mwe[0] && maddr[0] == 16'h4321 && mp[0] == 10) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_write_p10", 0, 16'(guard < 200), 16'd1);

        rst = 1'b1;
        model_reset();
        card_update();
        #1;
        check_dut(0);
        check_dut(1);
        repeat (2) tick();
        rst = 1'b0;

        repeat (1900) tick();
        chk("long_cycles", 0, 16'(nlong[0]), 16'd0);
        chk("long_cycles", 1, 16'(nlong[1]), 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aux_slot_host.md
# aux_slot_host

Apple IIe auxiliary-slot bus initiator: generates the motherboard-side timing (C7M, Q3, PHI0/PHI1, nPRAS/nPCAS, multiplexed MA, nWE, nWE80, nEN80, nC07X) and data-bus traffic that an aux-slot RAM card responds to. A simple command interface supplies one CPU-phase access per bus cycle, and a video address is fetched every PHI1 phase. Used as the host side of FPGA test fixtures and of an FPGA Apple IIe core driving the RAM2E card.

## Interface
- LONG_CYCLE, 1: enable the stretched bus cycle every 65th cycle (0 = all cycles 14 ticks).
- C14M  in  1  master clock; every timing edge is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  CPU access request.
- cmd_ready  out  1  request accepted this tick.
- cmd_addr  in  16  CPU address.
- cmd_we  in  1  1 = write.
- cmd_wdata  in  8  write data.
- cmd_aux  in  1  1 = access aux-slot memory (asserts nEN80).
- rsp_valid  out  1  one-tick read-data pulse.
- rsp_data  out  8  read data.
- vid_addr  in  16  video fetch address, sampled at P=0.
- vid_aux  in  1  capture aux video (VD) instead of main.
- vid_valid  out  1  one-tick pulse, vid_data updated.
- vid_data  out  8  captured video byte.
- C7M, Q3, PHI0, PHI1  out  1 each  bus clocks.
- nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X  out  1 each  bus strobes.
- MA  out  8  multiplexed DRAM address.
- MD  inout  8  6502 data bus; driven only during writes.
- VD  in  8  aux video data from card.

## Operation
- Phase counter P: 0..13 (0..15 on a long cycle). P 0..6 = PHI1 phase, P 7..end = PHI0 phase.
- Cycle counter 0..64; with LONG_CYCLE=1, cycle 64 is long; P 14,15 repeat every P13 output value.
- PHI1=1 at P 0..6, PHI0 = ~PHI1. C7M toggles every tick, C7M=1 at P=0. Q3=1 at P 0..3 and 7..10.
- Video phase: nPRAS=0 at P 2..6, nPCAS=0 at P 4..6; MA = vid_addr[7:0] at P 0..3, vid_addr[15:8] at P 4..6. At end of P6, vid_data <= VD if vid_aux, else 8'h00 (main video not modelled); vid_valid pulses at P0 of the next cycle.
- cmd_ready=1 only during P6; handshake completes at P6 when cmd_valid=1; command latched. No command accepted -> idle CPU phase: nPRAS/nPCAS still pulse (refresh), nWE=nEN80=nWE80=1, MD=Z.
- CPU phase: nPRAS=0 P 9..end, nPCAS=0 P 11..end; MA = addr[7:0] at P 7..10, addr[15:8] from P 11.
- nEN80=0 P 9..end when cmd_aux. nWE=0 P 9..end on writes; nWE80 = nWE when cmd_aux, else 1.
- MD = cmd_wdata P 8..end on writes, else Z.
- nC07X=0 P 7..end when addr[15:4]==12'hC07 (regardless of cmd_aux).
- Reads: MD sampled at the last PHI0 tick (P13, or P15 on long cycle); rsp_valid=1 with rsp_data for exactly the next tick (P0).
- All strobes return high and MD to Z at P0.

## Timing
- Reset (asynchronous, immediate): P=0, cycle=0, PHI1=1, PHI0=0, C7M=1, Q3=1, all n-strobes=1, MA=0, MD=Z, cmd_ready=0, rsp_valid=0, vid_valid=0, rsp_data=vid_data=0. Pending command or response dropped.
- First cycle after reset release starts at P=0.
- Command latency: accept at P6 -> read response at P0 of next cycle (8 ticks, 10 on long cycle).
- Throughput: at most one command per bus cycle; back-to-back cmd_valid served every cycle.
- cmd_* changes outside P6 have no effect; latched values hold through P end.

## Structure
- Package aux_slot_pkg: phase constants (PHI0 start=7, RAS/CAS start ticks, last-tick 13/15), C07X page value, cycle length 65.
- Sub-module aux_slot_timing: phase and cycle counters plus clock outputs (C7M, Q3, PHI0, PHI1) and a last_tick flag; top level adds strobes, muxing, and data paths.

## Test plan
- Reset then free-run LONG_CYCLE=0: PHI0 period 14 ticks, 7 high; Q3 4 high/3 low; nPRAS lows at P2 and P9 each cycle.
- Aux write addr=16'h1234, wdata=8'hA5, aux=1: MA=8'h34 at P7, 8'h12 at P11; nWE=nWE80=nEN80=0 P9-13; MD=8'hA5 P8-13.
- Aux read addr=16'h2000, card drives MD=8'h5A: rsp_valid one tick at next P0 with rsp_data=8'h5A; MD never driven.
- Write addr=16'hC073, wdata=8'h03, aux=0: nC07X=0 P7-13, nEN80 and nWE80 stay 1.
- LONG_CYCLE=1, 130 cycles: exactly cycles 64 and 129 last 16 ticks; read response follows P15.
- Assert RST at P10 of a write: all strobes high and MD=Z in the same tick; no rsp_valid afterwards.
